// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready input FIFO, internal baud timing,
// configurable data width, parity and stop bits.
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4,
  parameter int IDLE_LEVEL   = 1
) (
  input  logic                          uart_clk_tx,
  input  logic                          RST_n,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_tx_data,
  output logic                          uart_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int   BAUD_W   = $clog2(CLKS_PER_BIT);
  localparam int   AW       = $clog2(FIFO_DEPTH);
  localparam int   LVL_W    = AW + 1;
  localparam logic IDLE_BIT = (IDLE_LEVEL != 0);
  localparam logic ODD_PAR  = (PARITY_MODE == 1);

  generate
    if (PARITY_MODE < 0 || PARITY_MODE > 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
      $error("uart_tx_param: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- input FIFO ----------------
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]     level_q;
  logic                 full, empty, push, pop;
  logic [DATA_BITS-1:0] head;

  assign full       = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty      = (level_q == '0);
  assign tx_ready   = !full;
  assign push       = tx_valid && !full;
  assign head       = mem_q[rd_ptr_q];
  assign fifo_level = level_q;

  always_ff @(posedge uart_clk_tx) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge uart_clk_tx) begin
    if (!RST_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // ---------------- frame FSM ----------------
  state_t               state_q;
  logic [BAUD_W-1:0]    baud_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_q;
  logic                 line_q;
  logic                 busy_q;
  logic                 bit_end;

  assign bit_end = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

  // Pop from idle, or at the end of the last stop bit for a gapless next frame.
  always_comb begin
    pop = 1'b0;
    if (!empty) begin
      if (state_q == S_IDLE) pop = 1'b1;
      else if (state_q == S_STOP && bit_end && bit_q == 4'(STOP_BITS - 1)) pop = 1'b1;
    end
  end

  // Line and busy are registered from the current state, so they trail the
  // state register by one edge and each level lasts exactly CLKS_PER_BIT cycles.
  always_ff @(posedge uart_clk_tx) begin
    if (!RST_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      line_q  <= IDLE_BIT;
      busy_q  <= 1'b0;
    end else begin
      busy_q <= (state_q != S_IDLE);
      case (state_q)
        S_START:  line_q <= !IDLE_BIT;
        S_DATA:   line_q <= shift_q[0];
        S_PARITY: line_q <= par_q;
        default:  line_q <= IDLE_BIT;
      endcase

      if (state_q != S_IDLE) baud_q <= bit_end ? '0 : baud_q + 1'b1;

      case (state_q)
        S_IDLE: ;
        S_START: if (bit_end) begin
          state_q <= S_DATA;
          bit_q   <= '0;
        end
        S_DATA: if (bit_end) begin
          shift_q <= shift_q >> 1;
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_q   <= '0;
            state_q <= (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_q <= bit_q + 4'd1;
          end
        end
        S_PARITY: if (bit_end) begin
          state_q <= S_STOP;
          bit_q   <= '0;
        end
        S_STOP: if (bit_end) begin
          if (bit_q == 4'(STOP_BITS - 1)) state_q <= S_IDLE;
          else                            bit_q   <= bit_q + 4'd1;
        end
        default: state_q <= S_IDLE;
      endcase

      if (pop) begin
        shift_q <= head;
        par_q   <= (^head) ^ ODD_PAR;
        bit_q   <= '0;
        baud_q  <= '0;
        state_q <= S_START;
      end
    end
  end

  assign uart_tx_data = line_q;
  assign uart_busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: four configurations share clock and reset;
// per-instance monitors decode frames and compare against queued expectations.
module tb_uart_tx_param;
  localparam int C = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] tx_d  [4];
  logic       tx_v  [4];
  logic       rdy   [4];
  logic       line  [4];
  logic       busy  [4];
  logic [2:0] lvl   [4];

  always #5 clk = ~clk;

  uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1),
                  .FIFO_DEPTH(4), .IDLE_LEVEL(1)) u_8n1 (
    .uart_clk_tx(clk), .RST_n(rst_n), .tx_data(tx_d[0]), .tx_valid(tx_v[0]),
    .tx_ready(rdy[0]), .uart_tx_data(line[0]), .uart_busy(busy[0]), .fifo_level(lvl[0]));

  uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1),
                  .FIFO_DEPTH(4), .IDLE_LEVEL(1)) u_8e1 (
    .uart_clk_tx(clk), .RST_n(rst_n), .tx_data(tx_d[1]), .tx_valid(tx_v[1]),
    .tx_ready(rdy[1]), .uart_tx_data(line[1]), .uart_busy(busy[1]), .fifo_level(lvl[1]));

  uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1),
                  .FIFO_DEPTH(4), .IDLE_LEVEL(1)) u_8o1 (
    .uart_clk_tx(clk), .RST_n(rst_n), .tx_data(tx_d[2]), .tx_valid(tx_v[2]),
    .tx_ready(rdy[2]), .uart_tx_data(line[2]), .uart_busy(busy[2]), .fifo_level(lvl[2]));

  uart_tx_param #(.CLKS_PER_BIT(C), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2),
                  .FIFO_DEPTH(4), .IDLE_LEVEL(1)) u_7n2 (
    .uart_clk_tx(clk), .RST_n(rst_n), .tx_data(tx_d[3][6:0]), .tx_valid(tx_v[3]),
    .tx_ready(rdy[3]), .uart_tx_data(line[3]), .uart_busy(busy[3]), .fifo_level(lvl[3]));

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          k;
    logic [15:0] frame;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   nbits [4] = '{10, 11, 11, 10};
  bit   mon_en[4];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic expect_frame(input int k, input logic [15:0] f, input string nm);
    exp_t e;
    e.k = k; e.frame = f; e.name = nm;
    sb.push_back(e);
  endtask

  // Frame bits on the line, index 0 = start bit; every bit must hold for C cycles.
  task automatic mon(input int k);
    forever begin
      @(negedge clk);
      if (mon_en[k] && busy[k] === 1'b1) begin
        logic [15:0] got;
        bit          stable;
        int          idx;
        got = '0; stable = 1'b1; idx = -1;
        for (int b = 0; b < nbits[k]; b++) begin
          for (int c = 0; c < C; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (c == 0) got[b] = line[k];
            else if (line[k] !== got[b]) stable = 1'b0;
            if (busy[k] !== 1'b1) stable = 1'b0;
          end
        end
        for (int i = 0; i < sb.size(); i++)
          if (idx < 0 && sb[i].k == k) idx = i;
        if (idx < 0) begin
          checks++; errors++;
          $display("FAIL unexpected frame on instance %0d: got 0x%0h expected none", k, got);
        end else begin
          exp_t e;
          e = sb[idx];
          sb.delete(idx);
          check({e.name, " frame bits"}, 32'(got), 32'(e.frame));
          check({e.name, " bit stability"}, 32'(stable), 32'd1);
        end
      end
    end
  endtask

  task automatic measure(input int k, input int exp_len, input string nm);
    int t, n;
    t = 0; n = 0;
    while (busy[k] !== 1'b1 && t < 40) begin @(negedge clk); t++; end
    while (busy[k] === 1'b1 && n < 2000) begin n++; @(negedge clk); end
    check({nm, " busy cycles"}, 32'(n), 32'(exp_len));
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 2000) begin @(negedge clk); t++; end
    check({nm, " frames outstanding"}, 32'(sb.size()), 32'd0);
  endtask

  task automatic send1(input int k, input logic [7:0] d);
    tx_d[k] = d;
    tx_v[k] = 1'b1;
    @(negedge clk);
    tx_v[k] = 1'b0;
    tx_d[k] = ~d;
  endtask

  initial begin
    fork
      mon(0); mon(1); mon(2); mon(3);
    join_none
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] t5_words [3];
    int         bad;
    t5_words[0] = 8'h3C; t5_words[1] = 8'h01; t5_words[2] = 8'h02;
    for (int k = 0; k < 4; k++) begin
      tx_v[k] = 1'b0; tx_d[k] = '0; mon_en[k] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) check("reset line idle", 32'(line[k]), 32'd1);
    check("reset busy", 32'(busy[0]), 32'd0);
    check("reset level", 32'(lvl[0]), 32'd0);
    check("reset ready", 32'(rdy[0]), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // 8N1 0xA5
    expect_frame(0, 16'h34A, "t1 8N1 0xA5");
    fork
      measure(0, 40, "t1");
      send1(0, 8'hA5);
    join
    drain("t1");

    // even / odd parity, 0x07
    expect_frame(1, 16'h60E, "t2 even 0x07");
    expect_frame(2, 16'h40E, "t2 odd 0x07");
    fork
      measure(1, 44, "t2 even");
      measure(2, 44, "t2 odd");
      begin
        tx_d[1] = 8'h07; tx_d[2] = 8'h07; tx_v[1] = 1'b1; tx_v[2] = 1'b1;
        @(negedge clk);
        tx_v[1] = 1'b0; tx_v[2] = 1'b0;
      end
    join
    drain("t2");

    // FIFO fill: six offered, five accepted, frames back-to-back
    expect_frame(0, 16'h222, "t3 0x11");
    expect_frame(0, 16'h224, "t3 0x12");
    expect_frame(0, 16'h226, "t3 0x13");
    expect_frame(0, 16'h228, "t3 0x14");
    expect_frame(0, 16'h22A, "t3 0x15");
    fork
      measure(0, 200, "t3 five frames");
      begin
        for (int i = 0; i < 6; i++) begin
          if (i == 5) begin
            check("t3 ready while full", 32'(rdy[0]), 32'd0);
            check("t3 level full", 32'(lvl[0]), 32'd4);
          end
          tx_d[0] = 8'(8'h11 + i);
          tx_v[0] = 1'b1;
          @(negedge clk);
        end
        tx_v[0] = 1'b0;
        check("t3 level after rejected push", 32'(lvl[0]), 32'd4);
      end
    join
    drain("t3");

    // 7 data bits, 2 stop bits
    expect_frame(3, 16'h3FE, "t4 7N2 0x7F");
    fork
      measure(3, 40, "t4");
      send1(3, 8'h7F);
    join
    drain("t4");

    // Latency: push at edge N, line low after N+2
    expect_frame(0, 16'h2B4, "t6 0x5A");
    tx_d[0] = 8'h5A; tx_v[0] = 1'b1;
    @(negedge clk);
    tx_v[0] = 1'b0;
    check("t6 N line", 32'(line[0]), 32'd1);
    check("t6 N busy", 32'(busy[0]), 32'd0);
    check("t6 N level", 32'(lvl[0]), 32'd1);
    @(negedge clk);
    check("t6 N+1 line", 32'(line[0]), 32'd1);
    check("t6 N+1 busy", 32'(busy[0]), 32'd0);
    check("t6 N+1 level", 32'(lvl[0]), 32'd0);
    @(negedge clk);
    check("t6 N+2 line", 32'(line[0]), 32'd0);
    check("t6 N+2 busy", 32'(busy[0]), 32'd1);
    drain("t6");

    // Reset mid-frame with two words queued
    mon_en[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_d[0] = t5_words[i]; tx_v[0] = 1'b1;
      @(negedge clk);
    end
    tx_v[0] = 1'b0;
    repeat (8) @(negedge clk);
    check("t5 busy before reset", 32'(busy[0]), 32'd1);
    check("t5 level before reset", 32'(lvl[0]), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5 line after reset", 32'(line[0]), 32'd1);
    check("t5 busy after reset", 32'(busy[0]), 32'd0);
    check("t5 level after reset", 32'(lvl[0]), 32'd0);
    rst_n = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy[0] !== 1'b0 || line[0] !== 1'b1) bad++;
    end
    check("t5 quiet cycles violated", 32'(bad), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
